// File: rtl/systolic_pkg.sv
// Shared types for the systolic array front end.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth per-lane delay line; depth 0 is a wire.
module skew_line #(
    parameter int depth     = 1,
    parameter int data_size = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] d_i,
    output logic [data_size-1:0] q_o
);

    if (depth == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = clk ^ reset;
        assign q_o       = d_i;
    end else begin : g_dly
        logic [data_size-1:0] stage_q [depth];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < depth; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < depth; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[depth-1];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Turns unskewed A/B beat vectors into the diagonal wavefront a systolic
// array expects, and emits the phase-alignment pulse for the first beat.
//
//   state     | meaning
//   ST_IDLE   | no tile in flight, waiting for the first beat
//   ST_STREAM | one beat slot per cycle, beat_q = position in tile
//   ST_DRAIN  | flushing the skew lines with zeros, source stalled
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [data_size*size-1:0] a_in,
    input  logic [data_size*size-1:0] b_in,
    output logic [data_size*size-1:0] a_out,
    output logic [data_size*size-1:0] b_out,
    output logic                      reset_counter,
    output logic                      busy,
    output logic                      underrun
);

    localparam int W          = data_size * size;
    localparam int CW         = (size > 1) ? $clog2(size) : 1;
    localparam int DRAIN_LOAD = (size > 2) ? size - 3 : 0;
    localparam logic [CW-1:0] LAST_BEAT = CW'(size - 1);

    feeder_state_t state_q;
    logic [CW-1:0] beat_q;
    logic [CW-1:0] drain_q;
    logic [W-1:0]  a_vec_q, b_vec_q;
    logic [W-1:0]  a_vec_d, b_vec_d;
    logic          rc_q;
    logic          underrun_q;
    logic          hs;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] b);
        return (b == LAST_BEAT) ? '0 : b + 1'b1;
    endfunction

    // At a tile boundary the slot is only offered when the source has a beat,
    // so the boundary cycle itself already counts as the first drain cycle.
    assign in_ready = !reset &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_STREAM) && ((beat_q != '0) || in_valid)));
    assign hs       = in_valid && in_ready;
    assign a_vec_d  = hs ? a_in : '0;
    assign b_vec_d  = hs ? b_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            drain_q    <= '0;
            a_vec_q    <= '0;
            b_vec_q    <= '0;
            rc_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            a_vec_q <= a_vec_d;
            b_vec_q <= b_vec_d;
            rc_q    <= (state_q == ST_IDLE) && hs;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_q <= ST_STREAM;
                        beat_q  <= wrap_inc('0);
                    end
                end
                ST_STREAM: begin
                    if (beat_q != '0) begin
                        beat_q <= wrap_inc(beat_q);
                        if (!in_valid) underrun_q <= 1'b1;
                    end else if (in_valid) begin
                        beat_q <= wrap_inc('0);
                    end else if (size > 2) begin
                        state_q <= ST_DRAIN;
                        drain_q <= CW'(DRAIN_LOAD);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) state_q <= ST_IDLE;
                    else               drain_q <= drain_q - 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < size; k++) begin : g_lane
        skew_line #(.depth(k), .data_size(data_size)) u_a (
            .clk   (clk),
            .reset (reset),
            .d_i   (a_vec_q[data_size*(size-k)-1 -: data_size]),
            .q_o   (a_out[data_size*(size-k)-1 -: data_size])
        );
        skew_line #(.depth(k), .data_size(data_size)) u_b (
            .clk   (clk),
            .reset (reset),
            .d_i   (b_vec_q[data_size*(size-k)-1 -: data_size]),
            .q_o   (b_out[data_size*(size-k)-1 -: data_size])
        );
    end

    assign reset_counter = rc_q;
    assign busy          = (state_q != ST_IDLE);
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed tile tables plus random traffic
// against a per-cycle behavioural model of the feeder.
module tb_systolic_skew_feeder;

    localparam int SZ = 3;
    localparam int DS = 16;
    localparam int W  = SZ * DS;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in, a_out, b_out;
    logic         reset_counter, busy, underrun;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.size(SZ), .data_size(DS)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_in          (a_in),
        .b_in          (b_in),
        .a_out         (a_out),
        .b_out         (b_out),
        .reset_counter (reset_counter),
        .busy          (busy),
        .underrun      (underrun)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 in a tile (m_pos beats taken mod SZ), 2 draining.
    int           m_mode, m_pos, m_drain;
    bit           m_rc, m_under;
    logic [W-1:0] hist_a [SZ];
    logic [W-1:0] hist_b [SZ];

    typedef struct {
        bit           v;
        logic [W-1:0] a;
        logic [W-1:0] exp_a;
        bit           exp_rc;
        bit           exp_rdy;
        bit           exp_busy;
    } vec_t;
    vec_t tv [7];

    function automatic logic [W-1:0] pk(input int l0, input int l1, input int l2);
        return {16'(l0), 16'(l1), 16'(l2)};
    endfunction

    function automatic vec_t mk(input bit v, input logic [W-1:0] a, input logic [W-1:0] e,
                                input bit rc, input bit rdy, input bit bsy);
        vec_t r;
        r.v = v; r.a = a; r.exp_a = e; r.exp_rc = rc; r.exp_rdy = rdy; r.exp_busy = bsy;
        return r;
    endfunction

    function automatic logic [DS-1:0] lane0(input logic [W-1:0] v);
        return v[W-1 -: DS];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_drain = 0; m_rc = 0; m_under = 0;
        for (int k = 0; k < SZ; k++) begin
            hist_a[k] = '0;
            hist_b[k] = '0;
        end
    endtask

    // One clock cycle: drive, check against model, advance model.
    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        bit           rdy, acc;
        logic [W-1:0] ea, eb;
        @(negedge clk);
        in_valid = v; a_in = a; b_in = b;
        #1;
        rdy = (m_mode == 0) || (m_mode == 1 && (m_pos != 0 || v));
        acc = v && rdy;
        for (int k = 0; k < SZ; k++) begin
            ea[DS*(SZ-k)-1 -: DS] = hist_a[k][DS*(SZ-k)-1 -: DS];
            eb[DS*(SZ-k)-1 -: DS] = hist_b[k][DS*(SZ-k)-1 -: DS];
        end
        chk ("model a_out", a_out, ea);
        chk ("model b_out", b_out, eb);
        chk1("model in_ready", in_ready, rdy);
        chk1("model busy", busy, m_mode != 0);
        chk1("model reset_counter", reset_counter, m_rc);
        chk1("model underrun", underrun, m_under);
        m_rc = (m_mode == 0) && acc;
        for (int k = SZ - 1; k > 0; k--) begin
            hist_a[k] = hist_a[k-1];
            hist_b[k] = hist_b[k-1];
        end
        hist_a[0] = acc ? a : '0;
        hist_b[0] = acc ? b : '0;
        case (m_mode)
            0: if (acc) begin m_mode = 1; m_pos = 1 % SZ; end
            1: begin
                if (m_pos != 0) begin
                    if (!v) m_under = 1;
                    m_pos = (m_pos + 1) % SZ;
                end else if (v) begin
                    m_pos = 1 % SZ;
                end else begin
                    m_drain = SZ - 2;
                    m_mode  = (m_drain > 0) ? 2 : 0;
                end
            end
            default: begin
                m_drain--;
                if (m_drain == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk ("reset a_out", a_out, '0);
        chk ("reset b_out", b_out, '0);
        chk1("reset in_ready", in_ready, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset reset_counter", reset_counter, 1'b0);
        chk1("reset underrun", underrun, 1'b0);
        model_reset();
        repeat (hold) @(negedge clk);
        #1;
        chk1("reset held in_ready", in_ready, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            step(tv[i].v, tv[i].a, ~tv[i].a);
            chk ({tag, " a_out"}, a_out, tv[i].exp_a);
            chk1({tag, " reset_counter"}, reset_counter, tv[i].exp_rc);
            chk1({tag, " in_ready"}, in_ready, tv[i].exp_rdy);
            chk1({tag, " busy"}, busy, tv[i].exp_busy);
        end
    endtask

    initial begin
        bit           exp_busy31 [10];
        logic [W-1:0] held;
        int           pct [3];

        tv[0] = mk(1, pk(1, 2, 3), pk(0, 0, 0), 0, 1, 0);
        tv[1] = mk(1, pk(4, 5, 6), pk(1, 0, 0), 1, 1, 1);
        tv[2] = mk(1, pk(7, 8, 9), pk(4, 2, 0), 0, 1, 1);
        tv[3] = mk(0, pk(0, 0, 0), pk(7, 5, 3), 0, 0, 1);
        tv[4] = mk(0, pk(0, 0, 0), pk(0, 8, 6), 0, 0, 1);
        tv[5] = mk(0, pk(0, 0, 0), pk(0, 0, 9), 0, 1, 0);
        tv[6] = mk(0, pk(0, 0, 0), pk(0, 0, 0), 0, 1, 0);
        exp_busy31 = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        pct = '{90, 50, 75};

        reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
        model_reset();
        do_reset(2);
        step(0, '0, '0);

        run_table("t030");

        // six back-to-back beats: two tiles, one alignment pulse
        for (int i = 0; i < 10; i++) begin
            step(i < 6, pk(i + 10, i + 20, i + 30), pk(i + 40, i + 50, i + 60));
            chk1("t031 busy", busy, exp_busy31[i]);
            chk1("t031 reset_counter", reset_counter, i == 1);
            if (i == 6) chk1("t031 in_ready c6", in_ready, 1'b0);
            if (i == 8) chk1("t031 in_ready c8", in_ready, 1'b1);
        end

        // mid-tile bubble at cycle 1
        for (int i = 0; i < 8; i++) begin
            step(i == 0 || i == 2, pk(100 + i, 200 + i, 300 + i), pk(1, 2, 3));
            if (i == 2) chk("t032 lane0 bubble", 48'(lane0(a_out)), 48'd0);
            chk1("t032 underrun", underrun, i >= 2);
            if (i == 5) chk1("t032 idle in_ready", in_ready, 1'b1);
            if (i == 5) chk1("t032 idle busy", busy, 1'b0);
        end

        // beat offered during drain waits for idle
        held = pk(16'hABCD, 16'h1234, 16'h5678);
        for (int i = 0; i < 11; i++) begin
            step(i <= 2 || (i >= 4 && i <= 7), (i >= 4) ? held : pk(i + 1, i + 2, i + 3), held);
            if (i == 3 || i == 4) chk1("t033 in_ready drain", in_ready, 1'b0);
            if (i == 5) chk1("t033 in_ready accept", in_ready, 1'b1);
            if (i == 6) chk1("t033 reset_counter", reset_counter, 1'b1);
            if (i == 6) chk("t033 lane0", 48'(lane0(a_out)), 48'(lane0(held)));
        end

        // reset in cycle 2 of a tile, then a clean tile
        step(1, pk(9, 9, 9), pk(8, 8, 8));
        step(1, pk(7, 7, 7), pk(6, 6, 6));
        do_reset(2);
        step(0, '0, '0);
        run_table("t034");

        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 99) < pct[blk],
                     {16'($urandom), 16'($urandom), 16'($urandom)},
                     {16'($urandom), 16'($urandom), 16'($urandom)});
            end
            do_reset(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter size, default 3: array dimension, lanes per vector, beats per tile.
REQ-002 SHALL have parameter data_size, default 16: bits per lane element.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a_in/b_in carry a beat.
REQ-007 in_ready  output  1  beat accepted on the clk edge where in_valid && in_ready.
REQ-008 a_in, b_in  input  data_size*size  unskewed A and B vectors; lane k = bits data_size*(size-k)-1 down to data_size*(size-k-1).
REQ-009 a_out, b_out  output  data_size*size  skewed streams to the systolic array; same lane packing.
REQ-010 reset_counter  output  1  one-cycle alignment pulse to the array's phase counter.
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 underrun  output  1  sticky mid-tile bubble flag.

Function
REQ-013 SHALL implement states IDLE, STREAM, DRAIN.
REQ-014 IDLE: in_ready=1; accepted beat -> STREAM with beat_cnt=1.
REQ-015 STREAM: in_ready=1; every cycle consumes one beat slot; beat_cnt counts 0..size-1 and wraps.
REQ-016 STREAM slot with in_valid=0 and beat_cnt!=0 (mid-tile) SHALL inject an all-zero vector and set underrun.
REQ-017 STREAM at tile boundary (beat_cnt==0): in_valid=1 -> continue STREAM with no gap; in_valid=0 -> DRAIN, no beat consumed.
REQ-018 DRAIN: in_ready=0; lasts exactly size-1 cycles injecting zero vectors, then IDLE.
REQ-019 Skew: lane k of a_out and b_out SHALL equal lane k of the beat accepted 1+k cycles earlier (lane 0 registered, latency 1).
REQ-020 Lane slots with no beat (IDLE, DRAIN, bubbles) SHALL propagate zeros through the delay lines.
REQ-021 reset_counter SHALL be registered and high exactly in the cycle a_out lane 0 carries beat 0 of a tile entered from IDLE; never for back-to-back tiles.
REQ-022 Data SHALL pass bit-exact; no arithmetic on data.
REQ-023 in_valid during DRAIN SHALL NOT be consumed; beat held by source until IDLE.

Reset
REQ-024 On reset: state IDLE, beat_cnt 0, all delay lines 0, a_out/b_out 0, reset_counter 0, busy 0, underrun 0.
REQ-025 in_ready SHALL be 0 while reset is high, 1 in the first cycle after release.
REQ-026 Reset mid-STREAM SHALL discard in-flight beats immediately; no reset_counter pulse emitted.
REQ-027 underrun SHALL clear only by reset.

Structure
REQ-028 State enum feeder_state_t SHALL live in shared package systolic_pkg alongside the existing gdo arithmetic package.
REQ-029 Per-lane delay SHALL be sub-module skew_line (parameters depth, data_size), instantiated 2*size times with depth=k for lane k (depth 0 = pass-through of the output register).

Verification (size=3, data_size=16, beat 0 accepted at cycle 0)
REQ-030 Single tile a_in lanes {1,2,3},{4,5,6},{7,8,9} at cycles 0-2 -> reset_counter=1 at cycle 1 only; a_out lane0 1,4,7 cycles 1-3; lane1 2,5,8 cycles 2-4; lane2 3,6,9 cycles 3-5; zeros otherwise; DRAIN cycles 3-4; in_ready=1 again at cycle 5.
REQ-031 Six consecutive valid beats -> one reset_counter pulse (cycle 1), no DRAIN until cycle 6, busy high cycles 1-7.
REQ-032 in_valid=0 at cycle 1 of a tile -> lane0 of a_out = 0 at cycle 2, underrun=1 and stays 1; tile still ends after cycle 2.
REQ-033 in_valid=1 held through DRAIN -> in_ready=0 cycles 3-4, beat accepted cycle 5, new reset_counter pulse at cycle 6.
REQ-034 reset asserted at cycle 2 of a tile -> all outputs 0 immediately, in_ready=0 during reset; after release, a new tile yields normal REQ-030 timing.
